bcd_counter_n: RTL and testbench

- Parametrised N-digit synchronous BCD up/down counter; next generation of the team's fixed 6-digit decade counter used in the frequency-meter datapath.
- Adds runtime direction, a working count enable, parallel BCD load with digit validation, a registered terminal-count pulse and a sticky overflow flag.
- Sits between the gated input-frequency clock domain and the display/latch logic.

---
 rtl/bcd_counter_n.sv | 109 ++++++++++
 tb/tb_bcd_counter_n.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_n.sv
// N-digit synchronous BCD up/down counter with validated parallel load, terminal-count pulse and sticky overflow.
// Define BCD_COUNTER_SAT_EN to saturate at all-9s / all-0s instead of wrapping.

module bcd_digit (
    input  logic [3:0] cur,
    input  logic       up,
    input  logic       step,
    output logic [3:0] nxt,
    output logic       term
);
    // Invalid digits (>9) count as 9 going up, so they wrap and carry.
    // Going down, they just decrement.
    always_comb begin
        term = up ? (cur >= 4'd9) : (cur == 4'd0);
        nxt  = cur;
        if (step) begin
            if (term)
                nxt = up ? 4'd0 : 4'd9;
            else
                nxt = up ? cur + 4'd1 : cur - 4'd1;
        end
    end
endmodule

module bcd_counter_n #(
    parameter int DIGITS     = 6,
    parameter bit LOAD_CHECK = 1'b1
) (
    input  logic                F_IN,
    input  logic                CLR,
    input  logic                ENA,
    input  logic                UP,
    input  logic                LOAD,
    input  logic [4*DIGITS-1:0] D,
    output logic [4*DIGITS-1:0] Q,
    output logic                TC,
    output logic                OVF,
    output logic                ERR
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0]    q_nxt;
    logic [DIGITS-1:0] term;
    logic [DIGITS:0]   step;
    logic            wrap;
    logic            d_bad;
    logic            load_ok;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            bcd_digit u_dig (
                .cur  (Q[4*g +: 4]),
                .up   (UP),
                .step (step[g]),
                .nxt  (q_nxt[4*g +: 4]),
                .term (term[g])
            );
        end
    endgenerate

    // Digit k steps only when every lower digit sits at its terminal value.
    always_comb begin
        step[0] = 1'b1;
        for (int k = 1; k <= DIGITS; k++)
            step[k] = step[k-1] & term[k-1];
    end

    assign wrap = step[DIGITS];

    always_comb begin
        d_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++)
            d_bad = d_bad | (D[4*k +: 4] > 4'd9);
    end

    assign load_ok = !LOAD_CHECK || !d_bad;

    always_ff @(posedge F_IN) begin
        if (CLR) begin
            Q   <= '0;
            TC  <= 1'b0;
            OVF <= 1'b0;
            ERR <= 1'b0;
        end else begin
            TC  <= 1'b0;
            ERR <= 1'b0;
            if (LOAD) begin
                if (load_ok)
                    Q <= D;
                else
                    ERR <= 1'b1;
            end else if (ENA) begin
`ifdef BCD_COUNTER_SAT_EN
                if (wrap)
                    OVF <= 1'b1;
                else
                    Q <= q_nxt;
`else
                Q <= q_nxt;
                if (wrap) begin
                    TC  <= 1'b1;
                    OVF <= 1'b1;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n: a 6-digit unchecked-load instance and a 2-digit checked-load instance.
module tb_bcd_counter_n;
`ifdef BCD_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr6 = 0, ena6 = 0, up6 = 0, load6 = 0;
    logic [23:0] d6 = '0, q6;
    logic        tc6, ovf6, err6;

    logic        clr2 = 0, ena2 = 0, up2 = 0, load2 = 0;
    logic [7:0]  d2 = '0, q2;
    logic        tc2, ovf2, err2;

    int checks = 0;
    int errors = 0;

    bcd_counter_n #(.DIGITS(6), .LOAD_CHECK(1'b0)) u6 (
        .F_IN(clk), .CLR(clr6), .ENA(ena6), .UP(up6), .LOAD(load6), .D(d6),
        .Q(q6), .TC(tc6), .OVF(ovf6), .ERR(err6)
    );

    bcd_counter_n #(.DIGITS(2), .LOAD_CHECK(1'b1)) u2 (
        .F_IN(clk), .CLR(clr2), .ENA(ena2), .UP(up2), .LOAD(load2), .D(d2),
        .Q(q2), .TC(tc2), .OVF(ovf2), .ERR(err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step6(input logic c, input logic l, input logic e, input logic u, input logic [23:0] d);
        @(negedge clk);
        clr6 = c; load6 = l; ena6 = e; up6 = u; d6 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic c, input logic l, input logic e, input logic u, input logic [7:0] d);
        @(negedge clk);
        clr2 = c; load2 = l; ena2 = e; up2 = u; d2 = d;
        @(posedge clk);
        #1;
    endtask

    logic tc_seen;

    initial begin
        // ---- 6 digits: reset then 1234 up-counts
        step6(1, 0, 0, 1, '0);
        chk("u6_rst_q", q6, 0);
        chk("u6_rst_tc", tc6, 0);
        chk("u6_rst_ovf", ovf6, 0);
        chk("u6_rst_err", err6, 0);
        tc_seen = 1'b0;
        for (int i = 0; i < 1234; i++) begin
            step6(0, 0, 1, 1, '0);
            tc_seen = tc_seen | tc6;
        end
        chk("u6_cnt1234_q", q6, 24'h001234);
        chk("u6_cnt1234_tc_never", tc_seen, 0);
        chk("u6_cnt1234_ovf", ovf6, 0);

        // ---- unchecked load of invalid digits
        step6(0, 1, 1, 1, 24'h00000A);
        chk("u6_rawload_q", q6, 24'h00000A);
        chk("u6_rawload_err", err6, 0);
        step6(0, 0, 1, 1, '0);
        chk("u6_inv_up_q", q6, 24'h000010);
        step6(0, 1, 0, 0, 24'h00000B);
        step6(0, 0, 1, 0, '0);
        chk("u6_inv_dn_q", q6, 24'h00000A);
        chk("u6_inv_dn_tc", tc6, 0);
        step6(0, 1, 0, 1, 24'h999999);
        step6(0, 0, 1, 1, '0);
        chk("u6_wrap_q", q6, SAT ? 24'h999999 : 24'h000000);
        chk("u6_wrap_tc", tc6, SAT ? 0 : 1);
        chk("u6_wrap_ovf", ovf6, 1);

        // ---- 2 digits: up wrap
        step2(1, 0, 0, 1, '0);
        chk("u2_rst_q", q2, 0);
        chk("u2_rst_ovf", ovf2, 0);
        step2(0, 1, 0, 1, 8'h98);
        chk("u2_load98_q", q2, 8'h98);
        step2(0, 0, 1, 1, '0);
        chk("u2_up1_q", q2, 8'h99);
        chk("u2_up1_tc", tc2, 0);
        chk("u2_up1_ovf", ovf2, 0);
        step2(0, 0, 1, 1, '0);
        chk("u2_up2_q", q2, SAT ? 8'h99 : 8'h00);
        chk("u2_up2_tc", tc2, SAT ? 0 : 1);
        chk("u2_up2_ovf", ovf2, 1);
        for (int i = 0; i < 5; i++) begin
            step2(0, 0, 1, 1, '0);
            chk("u2_ovf_sticky", ovf2, 1);
            chk("u2_tc_after", tc2, 0);
        end
        chk("u2_up7_q", q2, SAT ? 8'h99 : 8'h05);

        // ---- down wrap; LOAD keeps OVF
        step2(0, 1, 0, 0, 8'h00);
        chk("u2_load00_q", q2, 8'h00);
        chk("u2_load_keeps_ovf", ovf2, 1);
        step2(0, 0, 1, 0, '0);
        chk("u2_dn1_q", q2, SAT ? 8'h00 : 8'h99);
        chk("u2_dn1_tc", tc2, SAT ? 0 : 1);
        for (int i = 0; i < 10; i++) step2(0, 0, 1, 0, '0);
        chk("u2_dn11_q", q2, SAT ? 8'h00 : 8'h89);
        chk("u2_dn11_tc", tc2, 0);

        // ---- CLR beats LOAD and ENA
        step2(0, 1, 0, 1, 8'h57);
        chk("u2_load57_q", q2, 8'h57);
        step2(1, 1, 1, 1, 8'h57);
        chk("u2_clrprio_q", q2, 0);
        chk("u2_clrprio_tc", tc2, 0);
        chk("u2_clrprio_ovf", ovf2, 0);
        chk("u2_clrprio_err", err2, 0);

        // ---- rejected load, ENA on same edge
        step2(0, 1, 0, 1, 8'h42);
        step2(0, 1, 1, 1, 8'h4A);
        chk("u2_badload_q", q2, 8'h42);
        chk("u2_badload_err", err2, 1);
        chk("u2_badload_tc", tc2, 0);
        step2(0, 0, 0, 1, '0);
        chk("u2_err_pulse_q", q2, 8'h42);
        chk("u2_err_pulse_end", err2, 0);
        step2(0, 1, 0, 1, 8'hA0);
        chk("u2_badhi_err", err2, 1);
        chk("u2_badhi_q", q2, 8'h42);

        // ---- enable toggle and direction change
        step2(0, 1, 0, 1, 8'h09);
        step2(0, 0, 1, 1, '0);
        chk("u2_ena1_q", q2, 8'h10);
        chk("u2_ena1_tc", tc2, 0);
        step2(0, 0, 0, 1, '0);
        chk("u2_ena0_q", q2, 8'h10);
        chk("u2_ena0_tc", tc2, 0);
        step2(0, 0, 1, 1, '0);
        chk("u2_ena1b_q", q2, 8'h11);
        chk("u2_ena1b_tc", tc2, 0);
        step2(0, 0, 1, 0, '0);
        chk("u2_dirdn_q", q2, 8'h10);
        step2(0, 0, 1, 0, '0);
        chk("u2_borrow_q", q2, 8'h09);
        step2(0, 0, 1, 1, '0);
        chk("u2_dirup_q", q2, 8'h10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
